fetch_unit: RTL
===============

# fetch_unit

- Instruction fetch stage for the NAND processor. Owns the program counter (PC) and requests instruction words from program memory.
- Drives `instructionbus` into `steuerwerk` using a valid/ready handshake.
- `steuerwerk` redirects it through a branch port; a redirect flushes all buffered and in-flight fetches.

## Interface
Parameters:
- `IW`, 16: instruction width.
- `AW`, 8: program address / PC width.
- `RESET_PC`, 0: first fetch address after reset.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `mem_addr` out AW: fetch address; held stable while `mem_req` is high and `mem_ack` is low.
- `mem_req` out 1: fetch request.
- `mem_ack` in 1: memory accepts the request; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in IW: fetched word.
- `instructionbus` out IW: head instruction.
- `instr_pc` out AW: address `instructionbus` was fetched from.
- `instr_valid` out 1: head entry present.
- `instr_ready` in 1: `steuerwerk` consumes the head.
- `branch_en` in 1: redirect request.
- `branch_target` in AW: new PC.

## Operation
- State:
  - `running` flag.
  - Fetch PC `fpc`.
  - Instruction buffer of DEPTH entries; each entry holds {word, pc}.
  - Occupancy `count`.
- Request rule:
  - `mem_req = running && count < DEPTH`.
  - `mem_addr = fpc`.
  - `mem_req` is a combinational function of registers only; it never depends on `branch_en`.
- Push: when `mem_req && mem_ack && !branch_en`, push {`mem_rdata`, `fpc`} and set `fpc <= fpc + 1`, modulo 2^AW (0xFF wraps to 0x00 at AW=8).
- Pop: on `instr_valid && instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- `instructionbus` and `instr_pc` are stable while `instr_valid && !instr_ready`.
- Branch: `branch_en` high in a cycle causes, at the next edge:
  - `fpc <= branch_target`;
  - buffer cleared (`count <= 0`);
  - any `mem_ack` in that cycle discarded.
  - A pop in that cycle still counts as consumed.
  - Branch takes priority over push.
- Requests are never withdrawn, and `mem_addr` never changes before ack. The only exception is a branch: a branch cycle ends the current request, whether or not it was acked. The memory treats `mem_req`/`mem_addr` as re-sampled every cycle.
- Reset (`rst_n` low at an edge):
  - `running <= 0`, `count <= 0`, `fpc <= RESET_PC`.
  - This applies even mid-request. Memory responses during reset are ignored.

## Timing
- Reset output values: `mem_req` 0, `mem_addr` RESET_PC, `instr_valid` 0, `instructionbus` 0, `instr_pc` 0.
- First edge with `rst_n` high sets `running`. `mem_req` rises in the following cycle.
- Latency: from an ack at edge N, `instr_valid` is 1 after edge N (next cycle).
- Zero-wait throughput:
  - DEPTH 1: one instruction per 2 cycles.
  - DEPTH 2: one instruction per cycle while `instr_ready` is high.
- Branch at edge N:
  - `instr_valid` is 0 in cycle N+1.
  - `mem_addr` = target in cycle N+1.
  - First target instruction is valid in cycle N+2 with a zero-wait memory.
- Full buffer: `mem_req` is 0 until a pop. With DEPTH 2 it re-asserts the cycle after the pop edge.

## Configuration
- `FETCH_PREFETCH_EN`:
  - Defined: DEPTH = 2. The unit prefetches while the head waits, giving one instruction per cycle.
  - Undefined: DEPTH = 1. A single holding register; at most one instruction per 2 cycles.
- All handshake, branch and reset rules are identical in both builds.

## Structure
- Shared package `proz_pkg` holds:
  - `IW`, `AW`, `RESET_PC` defaults;
  - `instr_t` (IW-bit word);
  - `pc_t` (AW-bit);
  - `fetch_entry_t` {`instr_t`, `pc_t`}.
- Sub-module `fetch_buffer`:
  - Parameterised DEPTH FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, full, empty, head.
  - Flush takes priority over push.
- `fetch_unit` keeps `running`, `fpc` and the request logic.

## Test plan
- Reset: hold `rst_n` low for 3 cycles with `mem_ack`=1 and `mem_rdata`=0xBEEF.
  - Expect `mem_req`=0, `instr_valid`=0, `mem_addr`=0x00 throughout.
  - After release, `mem_req` is 1 one cycle after the first high edge.
- Zero-wait stream, `mem_rdata` = 0x1000 + addr, `instr_ready`=1.
  - Expect instructions 0x1000, 0x1001, 0x1002… with `instr_pc` 0, 1, 2.
  - Rate: 1/cycle with `FETCH_PREFETCH_EN`, 1 per 2 cycles without.
- Wait states: ack 3 cycles after each request.
  - `mem_addr` is constant while waiting.
  - `instr_valid` rises the cycle after each ack.
- Backpressure: `instr_ready`=0 for 5 cycles.
  - `instructionbus` is held.
  - `mem_req` is 0 once `count` = DEPTH.
  - No instruction is lost or duplicated after release.
- Branch: `branch_en` with target 0x40 in a cycle where `mem_ack`=1 at addr 0x05.
  - Word from 0x05 is dropped and the buffer is emptied.
  - Next `mem_addr` = 0x40; next valid `instr_pc` = 0x40.
- Wrap: branch to 0xFE and stream.
  - `instr_pc` sequence is 0xFE, 0xFF, 0x00, 0x01.

Source files
------------

// File: rtl/proz_pkg.sv
// Shared types and defaults for the NAND processor front end.
// FETCH_PREFETCH_EN selects a 2-entry fetch buffer instead of 1.
package proz_pkg;

  localparam int IW_DEF       = 16;
  localparam int AW_DEF       = 8;
  localparam int RESET_PC_DEF = 0;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef logic [IW_DEF-1:0] instr_t;
  typedef logic [AW_DEF-1:0] pc_t;

  typedef struct packed {
    instr_t word;
    pc_t    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of fetched {word, pc}; head is always slot 0.
// Ports: i_push/i_din in, i_pop, i_flush (beats push), o_full, o_empty, o_head.
module fetch_buffer
  import proz_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_din,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t      r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_widx;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[0];

  assign w_push = i_push && !i_flush && !o_full;
  assign w_pop  = i_pop && !o_empty;
  // slot the new entry lands in after any same-cycle shift
  assign w_widx = r_count - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && CW'(i) == w_widx) begin
          r_mem[i] <= i_din;
        end else if (w_pop && i < DEPTH - 1) begin
          r_mem[i] <= r_mem[(i + 1) % DEPTH];
        end
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, requests words, hands them on via valid/ready.
// Ports: clk, rst_n; mem_addr/mem_req/mem_ack/mem_rdata to program memory;
// instructionbus/instr_pc/instr_valid/instr_ready to steuerwerk;
// branch_en/branch_target redirect. FETCH_PREFETCH_EN sets buffer depth 2.
module fetch_unit #(
  parameter int IW       = proz_pkg::IW_DEF,
  parameter int AW       = proz_pkg::AW_DEF,
  parameter int RESET_PC = proz_pkg::RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] instructionbus,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_target
);

  import proz_pkg::*;

  logic          r_running;
  logic [AW-1:0] r_fpc;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  // request depends on registers only, never on branch_en
  assign mem_req  = r_running && !w_full;
  assign mem_addr = r_fpc;

  assign w_push = mem_req && mem_ack && !branch_en;
  assign w_pop  = instr_valid && instr_ready;

  assign w_entry.word = instr_t'(mem_rdata);
  assign w_entry.pc   = pc_t'(r_fpc);

  assign instr_valid    = !w_empty;
  assign instructionbus = IW'(w_head.word);
  assign instr_pc       = AW'(w_head.pc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_running <= 1'b0;
      r_fpc     <= AW'(RESET_PC);
    end else begin
      r_running <= 1'b1;
      if (branch_en) begin
        r_fpc <= branch_target;
      end else if (w_push) begin
        r_fpc <= r_fpc + AW'(1);
      end
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .i_flush (branch_en),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule
